// File: rtl/vga_timing_monitor.sv
// -----------------------------------------------------------------------------
// vga_timing_monitor
//
// Receive-side companion of the VGA timing generator. Watches the hs/vs/blank
// stream (sampled on pix_en), recovers the active-pixel coordinates, measures
// line length and lines per frame, compares them with the nominal totals and
// reports lock and error status.
//
// Ports:
//   Clk          system clock
//   Reset_n      asynchronous active-low reset
//   pix_en       one-Clk strobe per pixel; inputs are sampled only when high
//   hs, vs       horizontal / vertical sync, active low
//   blank        1 = active video, 0 = blanking
//   clr_err      synchronous clear of err_sticky
//   RecX, RecY   recovered column / row of the last active sample
//   rec_valid    RecX/RecY describe the sample just taken (and timing locked)
//   line_len     last measured line length in samples (saturates at 1023)
//   frame_lines  last measured lines per frame (saturates at 1023)
//   frame_count  completed frames, wraps 65535 -> 0
//   locked       nominal timing seen for LOCK_FRAMES consecutive frames
//   h_err        one-Clk pulse: completed line length != H_TOTAL
//   v_err        one-Clk pulse: completed frame line count != V_TOTAL
//   err_sticky   latched h_err/v_err, cleared by clr_err
// -----------------------------------------------------------------------------
module vga_timing_monitor #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        pix_en,
   input  logic        hs,
   input  logic        vs,
   input  logic        blank,
   input  logic        clr_err,
   output logic [9:0]  RecX,
   output logic [9:0]  RecY,
   output logic        rec_valid,
   output logic [9:0]  line_len,
   output logic [9:0]  frame_lines,
   output logic [15:0] frame_count,
   output logic        locked,
   output logic        h_err,
   output logic        v_err,
   output logic        err_sticky
);

   localparam logic [9:0] H_TOTAL_C = 10'(H_TOTAL);
   localparam logic [9:0] V_TOTAL_C = 10'(V_TOTAL);
   localparam logic [3:0] LOCK_C    = 4'(LOCK_FRAMES);

   // Increment that sticks at the 10-bit ceiling instead of wrapping.
   function automatic logic [9:0] sat_inc10(input logic [9:0] val);
      logic [9:0] res;
      if (val == 10'd1023) begin
         res = val;
      end else begin
         res = val + 10'd1;
      end
      return res;
   endfunction

   // Sync history and counters
   logic        hs_d_r;
   logic        vs_d_r;
   logic [9:0]  h_cnt_r;
   logic [9:0]  v_cnt_r;
   logic [9:0]  x_cnt_r;
   logic        first_line_r;
   logic        first_frame_r;
   logic        frame_bad_r;
   logic        line_active_r;
   logic [3:0]  lock_cnt_r;

   // Output registers
   logic        locked_r;
   logic [9:0]  rec_x_r;
   logic [9:0]  rec_y_r;
   logic        rec_valid_r;
   logic [9:0]  line_len_r;
   logic [9:0]  frame_lines_r;
   logic [15:0] frame_cnt_r;
   logic        h_err_r;
   logic        v_err_r;
   logic        err_sticky_r;

   // Combinational decode of the current sample
   logic        hs_fall_s;
   logic        vs_fall_s;
   logic [9:0]  h_len_s;
   logic [9:0]  v_len_s;
   logic        h_err_s;
   logic        v_err_s;
   logic        frame_good_s;
   logic [3:0]  lock_inc_s;

   // Edge detection, error decisions and lock counter increment for this sample.
   always_comb begin
      hs_fall_s = pix_en & hs_d_r & ~hs;
      vs_fall_s = pix_en & vs_d_r & ~vs;
      h_len_s   = sat_inc10(h_cnt_r);
      // A line edge coincident with the frame edge belongs to the closing frame.
      if (hs_fall_s) begin
         v_len_s = sat_inc10(v_cnt_r);
      end else begin
         v_len_s = v_cnt_r;
      end
      h_err_s      = hs_fall_s & ~first_line_r  & (h_len_s != H_TOTAL_C);
      v_err_s      = vs_fall_s & ~first_frame_r & (v_len_s != V_TOTAL_C);
      // An h_err on the closing sample still spoils the closing frame.
      frame_good_s = ~(frame_bad_r | h_err_s | v_err_s);
      if (lock_cnt_r >= LOCK_C) begin
         lock_inc_s = LOCK_C;
      end else begin
         lock_inc_s = lock_cnt_r + 4'd1;
      end
   end

   // Previous hs/vs samples for falling-edge detection.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hs_d_r <= 1'b1;
         vs_d_r <= 1'b1;
      end else if (pix_en) begin
         hs_d_r <= hs;
         vs_d_r <= vs;
      end else begin
         hs_d_r <= hs_d_r;
         vs_d_r <= vs_d_r;
      end
   end

   // Horizontal sample counter and line length capture.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         h_cnt_r      <= 10'd0;
         line_len_r   <= 10'd0;
         first_line_r <= 1'b1;
      end else if (hs_fall_s) begin
         h_cnt_r      <= 10'd0;
         line_len_r   <= h_len_s;
         first_line_r <= 1'b0;
      end else if (pix_en) begin
         h_cnt_r      <= sat_inc10(h_cnt_r);
      end else begin
         h_cnt_r      <= h_cnt_r;
      end
   end

   // Line counter, frame length capture and completed-frame counter.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         v_cnt_r       <= 10'd0;
         frame_lines_r <= 10'd0;
         first_frame_r <= 1'b1;
         frame_cnt_r   <= 16'd0;
      end else if (vs_fall_s) begin
         v_cnt_r       <= 10'd0;
         frame_lines_r <= v_len_s;
         first_frame_r <= 1'b0;
         if (!first_frame_r) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end else begin
            frame_cnt_r <= frame_cnt_r;
         end
      end else if (hs_fall_s) begin
         v_cnt_r       <= sat_inc10(v_cnt_r);
      end else begin
         v_cnt_r       <= v_cnt_r;
      end
   end

   // Error pulses: re-evaluated every Clk so they last exactly one cycle.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         h_err_r <= 1'b0;
         v_err_r <= 1'b0;
      end else begin
         h_err_r <= h_err_s;
         v_err_r <= v_err_s;
      end
   end

   // Sticky error flag; a new error beats a simultaneous clear.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         err_sticky_r <= 1'b0;
      end else if (h_err_s | v_err_s) begin
         err_sticky_r <= 1'b1;
      end else if (clr_err) begin
         err_sticky_r <= 1'b0;
      end else begin
         err_sticky_r <= err_sticky_r;
      end
   end

   // Per-frame bad-line memory, cleared when the frame closes.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_bad_r <= 1'b0;
      end else if (vs_fall_s) begin
         frame_bad_r <= 1'b0;
      end else if (h_err_s) begin
         frame_bad_r <= 1'b1;
      end else begin
         frame_bad_r <= frame_bad_r;
      end
   end

   // Lock tracking: count clean frames, drop at once on any line error.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         lock_cnt_r <= 4'd0;
         locked_r   <= 1'b0;
      end else if (vs_fall_s && !first_frame_r) begin
         if (frame_good_s) begin
            lock_cnt_r <= lock_inc_s;
            locked_r   <= (lock_inc_s == LOCK_C);
         end else begin
            lock_cnt_r <= 4'd0;
            locked_r   <= 1'b0;
         end
      end else if (h_err_s) begin
         lock_cnt_r <= lock_cnt_r;
         locked_r   <= 1'b0;
      end else begin
         lock_cnt_r <= lock_cnt_r;
         locked_r   <= locked_r;
      end
   end

   // Column recovery: count active samples since the last line edge.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         x_cnt_r     <= 10'd0;
         rec_x_r     <= 10'd0;
         rec_valid_r <= 1'b0;
      end else if (pix_en) begin
         rec_valid_r <= locked_r & blank;
         if (blank) begin
            rec_x_r <= x_cnt_r;
         end else begin
            rec_x_r <= rec_x_r;
         end
         if (hs_fall_s) begin
            x_cnt_r <= 10'd0;
         end else if (blank) begin
            x_cnt_r <= x_cnt_r + 10'd1;
         end else begin
            x_cnt_r <= x_cnt_r;
         end
      end else begin
         x_cnt_r     <= x_cnt_r;
         rec_x_r     <= rec_x_r;
         rec_valid_r <= rec_valid_r;
      end
   end

   // Row recovery: only lines that carried active video advance the row.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         line_active_r <= 1'b0;
         rec_y_r       <= 10'd0;
      end else if (pix_en) begin
         if (hs_fall_s) begin
            line_active_r <= 1'b0;
         end else if (blank) begin
            line_active_r <= 1'b1;
         end else begin
            line_active_r <= line_active_r;
         end
         if (vs_fall_s) begin
            rec_y_r <= 10'd0;
         end else if (hs_fall_s && line_active_r) begin
            rec_y_r <= rec_y_r + 10'd1;
         end else begin
            rec_y_r <= rec_y_r;
         end
      end else begin
         line_active_r <= line_active_r;
         rec_y_r       <= rec_y_r;
      end
   end

   assign RecX        = rec_x_r;
   assign RecY        = rec_y_r;
   assign rec_valid   = rec_valid_r;
   assign line_len    = line_len_r;
   assign frame_lines = frame_lines_r;
   assign frame_count = frame_cnt_r;
   assign locked      = locked_r;
   assign h_err       = h_err_r;
   assign v_err       = v_err_r;
   assign err_sticky  = err_sticky_r;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_monitor
//
// Scoreboard bench for vga_timing_monitor on a scaled-down raster (40x12).
// The driver emits hs/vs/blank samples, runs a sample-history reference model
// and queues the expected outputs; a monitor pops and compares after every
// sampled pix_en cycle.
// -----------------------------------------------------------------------------
module tb_vga_timing_monitor;

   localparam int H   = 40;
   localparam int V   = 12;
   localparam int LF  = 2;
   localparam int HA  = 24;
   localparam int HS0 = 28;
   localparam int HSW = 6;
   localparam int VA  = 8;
   localparam int VS0 = 9;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        pix_en;
   logic        hs;
   logic        vs;
   logic        blank;
   logic        clr_err;
   logic [9:0]  RecX;
   logic [9:0]  RecY;
   logic        rec_valid;
   logic [9:0]  line_len;
   logic [9:0]  frame_lines;
   logic [15:0] frame_count;
   logic        locked;
   logic        h_err;
   logic        v_err;
   logic        err_sticky;

   vga_timing_monitor #(.H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(LF)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en), .hs(hs), .vs(vs),
      .blank(blank), .clr_err(clr_err), .RecX(RecX), .RecY(RecY),
      .rec_valid(rec_valid), .line_len(line_len), .frame_lines(frame_lines),
      .frame_count(frame_count), .locked(locked), .h_err(h_err),
      .v_err(v_err), .err_sticky(err_sticky)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [9:0]  rx;
      logic [9:0]  ry;
      logic        rv;
      logic [9:0]  ll;
      logic [9:0]  fl;
      logic [15:0] fc;
      logic        lk;
      logic        he;
      logic        ve;
      logic        es;
   } obs_t;

   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_smp = 0;
   bit   clr_rand = 1'b0;

   // Tracking of recovered coordinates over one frame
   bit   trk = 1'b0;
   bit   got_first = 1'b0;
   int   mx, my, fx, fy;

   // Reference model state: positions expressed as sample indices and totals
   int   m_idx, m_last_hs, m_hs_since_vs, m_good_run, m_act, m_rows, m_fc;
   bit   m_seen_hs, m_seen_vs, m_prev_hs, m_prev_vs, m_frame_herr, m_had_act;
   int   m_rx, m_ll, m_fl;
   bit   m_rv, m_lk, m_es;

   task automatic model_reset();
      m_idx = 0; m_last_hs = -1; m_hs_since_vs = 0; m_good_run = 0;
      m_act = 0; m_rows = 0; m_fc = 0;
      m_seen_hs = 0; m_seen_vs = 0; m_prev_hs = 1; m_prev_vs = 1;
      m_frame_herr = 0; m_had_act = 0;
      m_rx = 0; m_ll = 0; m_fl = 0; m_rv = 0; m_lk = 0; m_es = 0;
   endtask

   task automatic model_step(input bit h, input bit v, input bit b, input bit c,
                             output obs_t o);
      bit hsf, vsf, he, ve, was_locked, bad;
      int len, fl;
      hsf = m_prev_hs && !h;
      vsf = m_prev_vs && !v;
      was_locked = m_lk;
      he = 0; ve = 0;
      if (hsf) begin
         len = m_idx - m_last_hs;
         if (len > 1023) len = 1023;
         he = m_seen_hs && (len != H);
         m_ll = len; m_last_hs = m_idx; m_seen_hs = 1;
      end
      if (vsf) begin
         fl = m_hs_since_vs + (hsf ? 1 : 0);
         if (fl > 1023) fl = 1023;
         m_fl = fl;
         ve = m_seen_vs && (fl != V);
         bad = m_frame_herr || he || ve;
         if (m_seen_vs) begin
            m_fc = (m_fc + 1) % 65536;
            if (bad) begin
               m_good_run = 0; m_lk = 0;
            end else begin
               m_good_run++; m_lk = (m_good_run >= LF);
            end
         end else if (he) m_lk = 0;
         m_seen_vs = 1; m_hs_since_vs = 0; m_frame_herr = 0;
      end else begin
         if (hsf) m_hs_since_vs++;
         if (he) begin m_frame_herr = 1; m_lk = 0; end
      end
      m_rv = was_locked && b;
      if (b) m_rx = m_act % 1024;
      if (hsf) m_act = 0; else if (b) m_act++;
      if (vsf) m_rows = 0; else if (hsf && m_had_act) m_rows++;
      if (hsf) m_had_act = 0; else if (b) m_had_act = 1;
      m_es = (c ? 1'b0 : m_es) | he | ve;
      m_idx++;
      m_prev_hs = h; m_prev_vs = v;
      o.rx = 10'(m_rx); o.ry = 10'(m_rows % 1024); o.rv = m_rv;
      o.ll = 10'(m_ll); o.fl = 10'(m_fl); o.fc = 16'(m_fc); o.lk = m_lk;
      o.he = he; o.ve = ve; o.es = m_es;
   endtask

   function automatic obs_t dut_obs();
      obs_t o;
      o.rx = RecX; o.ry = RecY; o.rv = rec_valid; o.ll = line_len;
      o.fl = frame_lines; o.fc = frame_count; o.lk = locked; o.he = h_err;
      o.ve = v_err; o.es = err_sticky;
      return o;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      obs_t o;
      o = dut_obs();
      n_cmp++;
      if (o !== '0) begin
         n_bad++;
         $display("FAIL %s: got outputs %h expected all zero", nm, o);
      end
   endtask

   // Issue one sample (with pix_en high for exactly one Clk) and queue its expectation.
   task automatic drive_sample(input bit h, input bit v, input bit b, input bit c);
      obs_t e;
      repeat ($urandom_range(0, 1)) @(negedge Clk);
      pix_en = 1'b1; hs = h; vs = v; blank = b; clr_err = c;
      model_step(h, v, b, c, e);
      exp_q.push_back(e);
      @(posedge Clk);
      @(negedge Clk);
      pix_en = 1'b0; clr_err = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      m_es = 1'b0;
      @(negedge Clk);
      clr_err = 1'b0;
   endtask

   task automatic gen_line(input int v, input int len, input int h0, input bit vah);
      for (int h = h0; h < len; h++) begin
         bit lh, lv, lb, lc;
         lh = !(h >= HS0 && h < HS0 + HSW);
         lb = (v < VA) && (h < HA);
         if (vah) lv = !((v == VS0 && h >= HS0) || v == VS0 + 1 || (v == VS0 + 2 && h < HS0));
         else     lv = !(v == VS0 || v == VS0 + 1);
         lc = clr_rand && ($urandom_range(0, 15) == 0);
         drive_sample(lh, lv, lb, lc);
      end
   endtask

   task automatic gen_frame(input int nl, input bit vah, input int bad_v, input int bad_len);
      for (int v = 0; v < nl; v++) gen_line(v, (v == bad_v) ? bad_len : H, 0, vah);
   endtask

   // Monitor: compare after every sampled cycle, check pulses are gone otherwise.
   always @(posedge Clk) begin
      logic took;
      obs_t e, a;
      took = pix_en && Reset_n;
      #1;
      if (took) begin
         n_smp++;
         n_cmp++;
         a = dut_obs();
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sample_%0d: output present but no expectation queued", n_smp);
         end else begin
            e = exp_q.pop_front();
            if (a !== e)
               begin
                  n_bad++;
                  $display("FAIL sample_%0d: got rx=%0d ry=%0d rv=%0b ll=%0d fl=%0d fc=%0d lk=%0b he=%0b ve=%0b es=%0b expected rx=%0d ry=%0d rv=%0b ll=%0d fl=%0d fc=%0d lk=%0b he=%0b ve=%0b es=%0b",
                     n_smp, a.rx, a.ry, a.rv, a.ll, a.fl, a.fc, a.lk, a.he, a.ve, a.es,
                     e.rx, e.ry, e.rv, e.ll, e.fl, e.fc, e.lk, e.he, e.ve, e.es);
               end
         end
         if (trk && rec_valid) begin
            if (!got_first) begin fx = RecX; fy = RecY; got_first = 1'b1; end
            if (RecX > mx) mx = RecX;
            if (RecY > my) my = RecY;
         end
      end else if (Reset_n) begin
         n_cmp++;
         if (h_err || v_err) begin
            n_bad++;
            $display("FAIL pulse_width: got h_err=%0b v_err=%0b expected 0 0 in idle cycle", h_err, v_err);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      Reset_n = 1'b0; pix_en = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0; clr_err = 1'b0;
      model_reset();
      #23;
      chk_zero("reset_outputs");
      @(negedge Clk); Reset_n = 1'b1;
      @(negedge Clk);

      // Nominal stream: lock after first (ignored) frame plus two good frames
      gen_frame(V, 1'b0, -1, 0);
      gen_frame(V, 1'b0, -1, 0);
      chk("locked_after_2", locked, 0);
      gen_frame(V, 1'b0, -1, 0);
      gen_frame(V, 1'b0, -1, 0);
      chk("line_len_nom", line_len, H);
      chk("frame_lines_nom", frame_lines, V);
      chk("locked_nom", locked, 1);
      chk("frame_count_nom", frame_count, 3);
      chk("sticky_nom", err_sticky, 0);

      // Coordinate range over one locked frame
      mx = 0; my = 0; got_first = 1'b0; trk = 1'b1;
      gen_frame(V, 1'b0, -1, 0);
      trk = 1'b0;
      chk("first_recx", fx, 0);
      chk("first_recy", fy, 0);
      chk("max_recx", mx, HA - 1);
      chk("max_recy", my, VA - 1);

      // Shortened line: error, unlock, relock after two clean frames, clear
      gen_frame(V, 1'b0, 3, H - 1);
      chk("sticky_after_short", err_sticky, 1);
      chk("locked_after_short", locked, 0);
      gen_frame(V, 1'b0, -1, 0);
      gen_frame(V, 1'b0, -1, 0);
      chk("relocked", locked, 1);
      pulse_clr();
      chk("sticky_cleared", err_sticky, 0);

      // Short frame, then coincident hs/vs edges
      gen_frame(V - 1, 1'b0, -1, 0);
      gen_frame(V, 1'b0, -1, 0);
      chk("frame_lines_short", frame_lines, V - 1);
      chk("locked_short_frame", locked, 0);
      chk("sticky_short_frame", err_sticky, 1);
      pulse_clr();
      repeat (3) gen_frame(V, 1'b1, -1, 0);
      chk("frame_lines_coinc", frame_lines, V);
      chk("locked_coinc", locked, 1);

      // Reset in the middle of a line
      gen_line(0, H, 0, 1'b1);
      gen_line(1, H, 0, 1'b1);
      gen_line(2, 15, 0, 1'b1);
      chk("locked_before_reset", locked, 1);
      #2 Reset_n = 1'b0;
      #1 chk_zero("midline_reset");
      model_reset();
      @(negedge Clk); Reset_n = 1'b1;
      @(negedge Clk);
      repeat (299) drive_sample(1'b1, 1'b1, 1'b0, 1'b0);
      drive_sample(1'b0, 1'b1, 1'b0, 1'b0);
      chk("partial_line_len", line_len, 300);
      chk("partial_line_herr", h_err, 0);
      gen_line(0, H, HS0 + 1, 1'b0);
      for (int v = 1; v < V; v++) gen_line(v, H, 0, 1'b0);
      gen_frame(V, 1'b0, -1, 0);

      // Over-long line saturates the length
      repeat (1100) drive_sample(1'b1, 1'b1, 1'b0, 1'b0);
      drive_sample(1'b0, 1'b1, 1'b0, 1'b0);
      chk("sat_line_len", line_len, 1023);
      chk("sat_herr", h_err, 1);
      chk("sat_sticky", err_sticky, 1);
      gen_line(0, H, HS0 + 1, 1'b0);
      for (int v = 1; v < V; v++) gen_line(v, H, 0, 1'b0);
      repeat (3) gen_frame(V, 1'b0, -1, 0);
      chk("locked_after_sat", locked, 1);

      // Frame counter wrap via preload
      force dut.frame_cnt_r = 16'hFFFF;
      @(negedge Clk);
      release dut.frame_cnt_r;
      m_fc = 65535;
      @(negedge Clk);
      chk("fc_preload", frame_count, 65535);
      gen_frame(V, 1'b0, -1, 0);
      chk("fc_wrap", frame_count, 0);

      // Randomized frames with occasional bad lines and clr_err pulses
      clr_rand = 1'b1;
      for (int f = 0; f < 6; f++) begin
         int nl, bv, bl;
         nl = $urandom_range(V - 1, V + 1);
         bv = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, nl - 1));
         bl = H + int'($urandom_range(0, 4)) - 2;
         gen_frame(nl, 1'b0, bv, bl);
      end
      clr_rand = 1'b0;

      repeat (3) @(negedge Clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
